// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: shared defaults and counter sizing for the input conditioner
package input_conditioner_pkg;
    localparam int CLK_HZ_DEF    = 125_000_000;
    localparam int TICK_HZ_DEF   = 1;
    localparam int DB_CYCLES_DEF = 2_500_000;
    localparam int BTN_W_DEF     = 4;
    localparam int SW_W_DEF      = 2;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/input_conditioner_debounce_cell.sv
// debounce_cell: 2-flop synchroniser, restartable debounce counter, stable level and rise pulse
module debounce_cell
    import input_conditioner_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);
    localparam int CW = cnt_w(DB_CYCLES);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          prev;
    logic          done;
    always_comb done = cnt == CW'(DB_CYCLES - 1);
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync    <= '0;
            cnt     <= '0;
            level_o <= 1'b0;
            prev    <= 1'b0;
            rise_o  <= 1'b0;
        end else begin
            sync    <= {sync[0], d_i};
            cnt     <= (sync[1] == level_o || done) ? '0 : cnt + 1'b1;
            level_o <= (sync[1] != level_o && done) ? sync[1] : level_o;
            prev    <= level_o;
            rise_o  <= level_o & ~prev;
        end
    end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: debounced buttons/switches with press pulses and a holdable tick/square-wave generator
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int CLK_HZ    = CLK_HZ_DEF,
    parameter int TICK_HZ   = TICK_HZ_DEF,
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int BTN_W     = BTN_W_DEF,
    parameter int SW_W      = SW_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [BTN_W-1:0] btn_i,
    input  logic [SW_W-1:0]  sw_i,
    input  logic             hold_i,
    output logic [BTN_W-1:0] btn_level_o,
    output logic [BTN_W-1:0] btn_pulse_o,
    output logic [SW_W-1:0]  sw_o,
    output logic             tick_o,
    output logic             time_o
);
    localparam int N      = BTN_W + SW_W;
    localparam int PERIOD = CLK_HZ / TICK_HZ;
    localparam int TW     = cnt_w(PERIOD);
    logic [N-1:0]    raw;
    logic [N-1:0]    level;
    logic [N-1:0]    rise;
    logic [SW_W-1:0] sw_rise_unused;
    logic [TW-1:0]   tcnt;
    logic [TW-1:0]   tcnt_nxt;
    logic            wrap;
    always_comb raw = {sw_i, btn_i};
    always_comb {sw_o, btn_level_o} = level;
    always_comb {sw_rise_unused, btn_pulse_o} = rise;
    for (genvar i = 0; i < N; i++) begin : g_db
        debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .d_i    (raw[i]),
            .level_o(level[i]),
            .rise_o (rise[i])
        );
    end
    always_comb begin
        wrap     = tcnt == TW'(PERIOD - 1);
        tcnt_nxt = hold_i ? tcnt : wrap ? '0 : tcnt + 1'b1;
    end
    // time_o tracks the counter's next value so its rising edge lands with tick_o
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tcnt   <= '0;
            tick_o <= 1'b0;
            time_o <= 1'b0;
        end else begin
            tcnt   <= tcnt_nxt;
            tick_o <= wrap & ~hold_i;
            time_o <= tcnt_nxt < TW'(PERIOD / 2);
        end
    end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed checks of debounce, pulses, tick, hold and reset behaviour
module tb_input_conditioner;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] btn = '0;
    logic [1:0] sw = '0;
    logic [3:0] btn_level;
    logic [3:0] btn_pulse;
    logic [1:0] sw_lvl;
    logic       tick;
    logic       tm;
    int         checks = 0;
    int         errors = 0;
    int         pulses;

    input_conditioner #(
        .CLK_HZ(20), .TICK_HZ(1), .DB_CYCLES(4), .BTN_W(4), .SW_W(2)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .btn_i      (btn),
        .sw_i       (sw),
        .hold_i     (hold),
        .btn_level_o(btn_level),
        .btn_pulse_o(btn_pulse),
        .sw_o       (sw_lvl),
        .tick_o     (tick),
        .time_o     (tm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        btn = 4'hF;
        sw = 2'b11;
        rst_n = 1'b0;
        step(3);
        chk("rst_lvl", 32'(btn_level), 32'h0);
        chk("rst_pulse", 32'(btn_pulse), 32'h0);
        chk("rst_sw", 32'(sw_lvl), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_time", 32'(tm), 32'h0);
        rst_n = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            step();
            if (k <= 8) begin
                chk("s1_lvl", 32'(btn_level), (k >= 6) ? 32'hF : 32'h0);
                chk("s1_pulse", 32'(btn_pulse), (k == 7) ? 32'hF : 32'h0);
                chk("s1_sw", 32'(sw_lvl), (k >= 6) ? 32'h3 : 32'h0);
            end
            chk("s4_tick", 32'(tick), 32'((k == 20) || (k == 40)));
            chk("s4_time", 32'(tm), 32'((k % 20) < 10));
        end

        btn = '0;
        sw = '0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(8);
        chk("s2_idle_lvl", 32'(btn_level), 32'h0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            btn[1] = (i % 2 == 0);
            step();
            pulses += int'(btn_pulse[1]);
            chk("s2_bounce_lvl", 32'(btn_level[1]), 32'h0);
        end
        btn[1] = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            step();
            pulses += int'(btn_pulse[1]);
            chk("s2_lvl", 32'(btn_level[1]), 32'(n >= 6));
            chk("s2_pulse", 32'(btn_pulse[1]), 32'(n == 7));
        end
        chk("s2_pulse_count", 32'(pulses), 32'd1);

        for (int k = 0; k < 13; k++) begin
            btn[2] = (k < 3);
            step();
            chk("s3_lvl", 32'(btn_level[2]), 32'h0);
            chk("s3_pulse", 32'(btn_pulse[2]), 32'h0);
        end

        btn = '0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(7);
        chk("s5_pre_time", 32'(tm), 32'h1);
        hold = 1'b1;
        for (int k = 8; k <= 20; k++) begin
            step();
            chk("s5_hold_tick", 32'(tick), 32'h0);
            chk("s5_hold_time", 32'(tm), 32'h1);
        end
        hold = 1'b0;
        for (int k = 21; k <= 45; k++) begin
            step();
            chk("s5_tick", 32'(tick), 32'(k == 33));
            chk("s5_time", 32'(tm), 32'((k <= 22) || (k >= 33 && k < 43)));
        end

        btn = 4'b1000;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(12);
        chk("s6_pre_lvl", 32'(btn_level), 32'h8);
        btn[0] = 1'b1;
        step(3);
        rst_n = 1'b0;
        step();
        chk("s6_rst_time", 32'(tm), 32'h0);
        chk("s6_rst_tick", 32'(tick), 32'h0);
        chk("s6_rst_lvl", 32'(btn_level), 32'h0);
        chk("s6_rst_pulse", 32'(btn_pulse), 32'h0);
        btn = '0;
        step(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step();
            chk("s6_tick", 32'(tick), 32'(k == 20));
            chk("s6_time", 32'(tm), 32'((k % 20) < 10));
            chk("s6_lvl", 32'(btn_level), 32'h0);
            chk("s6_pulse", 32'(btn_pulse), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
